// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// seg_pkg
// Shared constants for the multiplexed seven-segment scan controller:
// register offsets, SCAN register field positions, the active-low glyph
// table and a byte-enable merge helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  localparam logic [2:0] OFF_MASK = 3'd4;
  localparam logic [2:0] OFF_SCAN = 3'd5;

  // SCAN register layout: [19:0] divider, [31] enable
  localparam int SCAN_DIV_W  = 20;
  localparam int SCAN_EN_BIT = 31;

  // Active-low glyphs, bit6 = a ... bit0 = g. Packed so that GLYPH[n] is the
  // glyph for hex digit n (the highest index is listed first).
  localparam logic [15:0][6:0] GLYPH = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Replace each byte lane of old_v whose enable bit is set with wd_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] wd_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
//------------------------------------------------------------------------------
// seg7_decode
// Combinational nibble to active-low seven-segment decode with blank and
// decimal point.
//   nibble in  4  hex digit to show
//   blank  in  1  1 = all segments off
//   dp     in  1  1 = decimal point lit
//   seg    out 8  {dp, glyph[6:0]}, active-low
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    if (!blank) seg = {~dp, GLYPH[nibble]};
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
//------------------------------------------------------------------------------
// seg_scan_ctrl
// Memory-mapped multiplexed seven-segment controller. Scans GROUPS groups of
// DIGITS common-select digits with a shared run-time divider.
//   CLK   in  1               clock
//   RST   in  1               synchronous active-high reset
//   WE    in  1               register write strobe
//   BE    in  4               byte enables for WD
//   ADDR  in  3               word offset (0..GROUPS-1 DATA, 4 MASK, 5 SCAN)
//   WD    in  32              write data
//   RD    out 32              read data (combinational)
//   seg_o out GROUPS*8        per group {dp,glyph}, active-low
//   sel_o out GROUPS*DIGITS   per group one-hot digit select, active-high
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int GROUPS   = 2,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WE,
  input  logic [3:0]                 BE,
  input  logic [2:0]                 ADDR,
  input  logic [31:0]                WD,
  output logic [31:0]                RD,
  output logic [GROUPS*8-1:0]        seg_o,
  output logic [GROUPS*DIGITS-1:0]   sel_o
);

  localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int             DW   = 4 * DIGITS;
  localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

  logic [GROUPS-1:0][DW-1:0]   data_all;
  logic [31:0]                 mask;
  logic [SCAN_DIV_W-1:0]       divider;
  logic [SCAN_DIV_W-1:0]       counter;
  logic                        enable;
  logic [IW-1:0]               idx;
  logic [IW-1:0]               idx_nx;
  logic                        advance;

  assign advance = enable && (counter == '0);
  assign idx_nx  = (idx == LAST) ? '0 : idx + 1'b1;

  // Control registers and the shared scan counter / digit index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask    <= '0;
      divider <= SCAN_DIV_W'(SCAN_DIV);
      enable  <= 1'b1;
      counter <= SCAN_DIV_W'(SCAN_DIV);
      idx     <= LAST;
    end else begin
      if (WE && ADDR == OFF_MASK) mask <= be_merge(mask, WD, BE);
      if (WE && ADDR == OFF_SCAN) begin
        if (BE[0]) divider[7:0]   <= WD[7:0];
        if (BE[1]) divider[15:8]  <= WD[15:8];
        if (BE[2]) divider[19:16] <= WD[19:16];
        if (BE[3]) enable         <= WD[SCAN_EN_BIT];
      end
      // The reload uses the divider as it stands before any same-edge write,
      // so a divider write only matters from the following reload.
      if (advance) begin
        counter <= divider;
        idx     <= idx_nx;
      end else if (enable) begin
        counter <= counter - 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      logic [DW-1:0] data;
      logic [3:0]    nib;
      logic          blank;
      logic          dp;
      logic [7:0]    seg;

      // Latches sample the registers before any write on the advance edge,
      // so a coincident DATA/MASK write appears on the next visit.
      always_ff @(posedge CLK) begin
        if (RST) begin
          data  <= '0;
          nib   <= '0;
          blank <= 1'b0;
          dp    <= 1'b0;
        end else begin
          if (WE && ADDR == 3'(g)) data <= DW'(be_merge(32'(data), WD, BE));
          if (advance) begin
            nib   <= data[4*int'(idx_nx) +: 4];
            blank <= mask[g*4 + int'(idx_nx)];
            dp    <= mask[16 + g*4 + int'(idx_nx)];
          end
        end
      end

      assign data_all[g] = data;

      // Disabled display is forced dark through the blank input.
      seg7_decode u_dec (
        .nibble (nib),
        .blank  (blank | ~enable),
        .dp     (dp),
        .seg    (seg)
      );

      assign seg_o[8*g +: 8] = seg;

      for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign sel_o[g*DIGITS + d] = enable && (idx == IW'(d));
      end
    end
  endgenerate

  always_comb begin
    RD = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (ADDR == 3'(g)) RD = 32'(data_all[g]);
    end
    if (ADDR == OFF_MASK) RD = mask;
    if (ADDR == OFF_SCAN) begin
      RD[SCAN_DIV_W-1:0] = divider;
      RD[SCAN_EN_BIT]    = enable;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
//------------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with GROUPS=2, DIGITS=4, SCAN_DIV=5.
// Register behaviour comes from a vector table; scan timing, masks, disable,
// same-edge write and mid-scan reset come from hand-written sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_ctrl;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic [3:0]  BE;
  logic [2:0]  ADDR;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [15:0] seg_o;
  logic [7:0]  sel_o;

  int checks   = 0;
  int failures = 0;

  seg_scan_ctrl #(
    .GROUPS   (2),
    .DIGITS   (4),
    .SCAN_DIV (5)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (WE),
    .BE    (BE),
    .ADDR  (ADDR),
    .WD    (WD),
    .RD    (RD),
    .seg_o (seg_o),
    .sel_o (sel_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    ADDR = a;
    #1;
    check(name, RD, exp);
  endtask

  // Drives a write for one rising edge; returns at the following falling edge.
  task automatic wr(input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
    WE = 1'b1; ADDR = a; BE = b; WD = d;
    @(negedge CLK);
    WE = 1'b0; BE = 4'h0; WD = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic logic [7:0] exp_sel(input int d);
    logic [3:0] one;
    one = 4'b0001 << d;
    return {one, one};
  endfunction

  logic [7:0] digit_seg [4];

  initial begin
    WE = 1'b0; BE = 4'h0; ADDR = 3'd0; WD = '0; RST = 1'b1;

    //            we    addr  be       wd             expected RD
    vecs[0]  = '{1'b0, 3'd5, 4'b0000, 32'h0000_0000, 32'h8000_0005};
    vecs[1]  = '{1'b0, 3'd4, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b0, 3'd0, 4'b0000, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b1, 3'd0, 4'b1111, 32'h0000_1234, 32'h0000_1234};
    vecs[4]  = '{1'b1, 3'd0, 4'b0010, 32'hFFFF_AB00, 32'h0000_AB34};
    vecs[5]  = '{1'b1, 3'd1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vecs[6]  = '{1'b1, 3'd4, 4'b0101, 32'h1122_3344, 32'h0022_0044};
    vecs[7]  = '{1'b1, 3'd5, 4'b0100, 32'hFFFF_FFFF, 32'h800F_0005};
    vecs[8]  = '{1'b1, 3'd5, 4'b1000, 32'h0000_0000, 32'h000F_0005};
    vecs[9]  = '{1'b1, 3'd6, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{1'b1, 3'd7, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{1'b1, 3'd2, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{1'b1, 3'd5, 4'b1111, 32'h8000_0005, 32'h8000_0005};
    vecs[13] = '{1'b1, 3'd4, 4'b1111, 32'h0000_0000, 32'h0000_0000};

    digit_seg[0] = 8'hCF;  // "1"
    digit_seg[1] = 8'h92;  // "2"
    digit_seg[2] = 8'h86;  // "3"
    digit_seg[3] = 8'hCC;  // "4"

    // Register table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      WE = vecs[i].we; ADDR = vecs[i].addr; BE = vecs[i].be; WD = vecs[i].wd;
      @(negedge CLK);
      WE = 1'b0; BE = 4'h0; WD = '0;
      rd_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
    end

    // Reset state, then a full scan of 4321 on group 0
    do_reset();
    check("rst_sel", {24'h0, sel_o}, 32'h0000_0088);
    check("rst_seg", {16'h0, seg_o}, 32'h0000_8181);
    rd_check("rst_scan", 3'd5, 32'h8000_0005);
    wr(3'd0, 4'b1111, 32'h0000_4321);
    repeat (4) @(negedge CLK);
    check("pre_adv_sel", {24'h0, sel_o}, 32'h0000_0088);
    @(negedge CLK);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("scan_sel_d%0d", d), {24'h0, sel_o}, {24'h0, exp_sel(d)});
      check($sformatf("scan_seg_d%0d", d), {16'h0, seg_o}, {16'h0, 8'h81, digit_seg[d]});
      repeat (5) @(negedge CLK);
      check($sformatf("hold_sel_d%0d", d), {24'h0, sel_o}, {24'h0, exp_sel(d)});
      @(negedge CLK);
    end
    check("wrap_sel", {24'h0, sel_o}, 32'h0000_0011);

    // Blank digit 1 and dp on digit 0 of group 0
    wr(3'd4, 4'b1111, 32'h0001_0002);
    repeat (5) @(negedge CLK);
    check("blank_sel", {24'h0, sel_o}, 32'h0000_0022);
    check("blank_seg", {16'h0, seg_o}, 32'h0000_81FF);
    repeat (18) @(negedge CLK);
    check("dp_sel", {24'h0, sel_o}, 32'h0000_0011);
    check("dp_seg", {16'h0, seg_o}, 32'h0000_814F);

    // Divider 0: current count (4) still runs out before every-cycle stepping
    wr(3'd5, 4'b1111, 32'h8000_0000);
    rd_check("div0_rd", 3'd5, 32'h8000_0000);
    repeat (4) @(negedge CLK);
    check("div_no_restart", {24'h0, sel_o}, 32'h0000_0011);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check($sformatf("fast_sel_%0d", k), {24'h0, sel_o}, {24'h0, exp_sel(k % 4)});
    end

    // Disable: the same edge still advances once (enable was 1 before it)
    wr(3'd5, 4'b1111, 32'h0000_0000);
    check("dis_sel", {24'h0, sel_o}, 32'h0);
    check("dis_seg", {16'h0, seg_o}, 32'h0000_FFFF);
    repeat (10) @(negedge CLK);
    check("dis_sel_10", {24'h0, sel_o}, 32'h0);
    check("dis_seg_10", {16'h0, seg_o}, 32'h0000_FFFF);
    repeat (10) @(negedge CLK);
    check("dis_sel_20", {24'h0, sel_o}, 32'h0);
    check("dis_seg_20", {16'h0, seg_o}, 32'h0000_FFFF);

    // Re-enable resumes from the frozen digit 1 (blanked in group 0)
    wr(3'd5, 4'b1111, 32'h8000_0000);
    check("resume_sel", {24'h0, sel_o}, 32'h0000_0022);
    check("resume_seg", {16'h0, seg_o}, 32'h0000_81FF);
    @(negedge CLK);
    check("resume2_sel", {24'h0, sel_o}, 32'h0000_0044);
    check("resume2_seg", {16'h0, seg_o}, 32'h0000_8186);

    // DATA[1] written on the edge that advances to digit 0
    @(negedge CLK);
    wr(3'd1, 4'b1111, 32'h0000_000A);
    check("samedge_sel", {24'h0, sel_o}, 32'h0000_0011);
    check("samedge_old", {16'h0, seg_o}, 32'h0000_814F);
    rd_check("samedge_rd", 3'd1, 32'h0000_000A);
    repeat (4) @(negedge CLK);
    check("nextwrap_sel", {24'h0, sel_o}, 32'h0000_0011);
    check("nextwrap_new", {16'h0, seg_o}, 32'h0000_884F);

    // Reset mid-scan
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_sel", {24'h0, sel_o}, 32'h0000_0088);
    check("mid_rst_seg", {16'h0, seg_o}, 32'h0000_8181);
    rd_check("mid_rst_data1", 3'd1, 32'h0);
    rd_check("mid_rst_mask", 3'd4, 32'h0);
    rd_check("mid_rst_scan", 3'd5, 32'h8000_0005);
    RST = 1'b0;
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
